// File: rtl/dmem_responder.sv
// Direct-mapped, one-word-per-line, write-through/no-allocate data cache front end.
// Single-cycle read hits; misses and all writes go to the backing memory.
module dmem_responder #(
    parameter int NUM_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    input  logic        mem_stall,
    output logic        mem_resp,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata
);

    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [31:0]          data_r [NUM_LINES];
    logic                 mem_ready_r;
    logic [31:0]          mem_rdata_r;

    logic [IDX-1:0]       idx_s;
    logic [TAG_W-1:0]     tag_s;
    logic                 hit_s;
    logic                 accept_read_s;
    logic                 line_fill_s;
    logic                 line_merge_s;
    logic                 unused_addr_bits_s;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    assign idx_s              = mem_address[IDX+1:2];
    assign tag_s              = mem_address[31:IDX+2];
    assign hit_s              = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign unused_addr_bits_s = &{1'b0, mem_address[1:0]};

    assign pmem_address     = {mem_address[31:2], 2'b00};
    assign pmem_wdata       = mem_wdata;
    assign pmem_byte_enable = mem_byte_enable;
    assign mem_ready        = mem_ready_r;
    assign mem_rdata        = mem_rdata_r;

    // Next-state and handshake decode; a stall freezes IDLE and delays the WDONE acknowledge.
    always_comb begin
        state_next_s  = state_r;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        accept_read_s = 1'b0;
        line_fill_s   = 1'b0;
        line_merge_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_stall) begin
                    state_next_s = IDLE;
                end else if (mem_write) begin
                    state_next_s = WRITE;
                end else if (mem_read) begin
                    if (hit_s) begin
                        mem_resp      = 1'b1;
                        accept_read_s = 1'b1;
                    end else begin
                        state_next_s = FETCH;
                    end
                end else begin
                    mem_resp = 1'b1;
                end
            end
            FETCH: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    line_fill_s  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    line_merge_s = hit_s;
                    state_next_s = WDONE;
                end else begin
                    state_next_s = WRITE;
                end
            end
            WDONE: begin
                if (mem_stall) begin
                    state_next_s = WDONE;
                end else begin
                    mem_resp     = 1'b1;
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, valid bits and the registered CPU read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            valid_r     <= '0;
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            if (line_fill_s) begin
                valid_r[idx_s] <= 1'b1;
            end
            if (!mem_stall) begin
                mem_ready_r <= accept_read_s;
                if (accept_read_s) begin
                    mem_rdata_r <= data_r[idx_s];
                end
            end
        end
    end

    // Tag/data arrays carry no reset; updates are suppressed in a reset cycle so an
    // abandoned transaction never lands in a line.
    always_ff @(posedge clk) begin
        if (!rst && line_fill_s) begin
            tag_r[idx_s]  <= tag_s;
            data_r[idx_s] <= pmem_rdata;
        end else if (!rst && line_merge_s) begin
            data_r[idx_s] <= merge_bytes(data_r[idx_s], mem_wdata, mem_byte_enable);
        end
    end

    dmem_responder_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .mem_ready  (mem_ready),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write)
    );

endmodule

// Protocol properties of the responder, kept apart from the datapath.
module dmem_responder_checker (
    input logic clk,
    input logic rst,
    input logic mem_ready,
    input logic pmem_read,
    input logic pmem_write
);

    a_pmem_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(pmem_read && pmem_write));

    a_ready_not_during_pmem: assert property (@(posedge clk) disable iff (rst)
        mem_ready |-> !(pmem_read || pmem_write));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a cycle-stepped backing-memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic        mem_resp;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;

    int errors = 0;
    int checks = 0;

    int          lat = 3;
    int          cnt = 0;
    logic        pmem_manual = 1'b0;
    int          rd_txn = 0;
    int          wr_txn = 0;
    logic        both_seen = 1'b0;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    logic [3:0]  last_wr_be;
    logic [31:0] bmem [logic [31:0]];

    always #5 clk = ~clk;

    dmem_responder #(.NUM_LINES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_byte_enable  (mem_byte_enable),
        .mem_wdata        (mem_wdata),
        .mem_stall        (mem_stall),
        .mem_resp         (mem_resp),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_resp        (pmem_resp),
        .pmem_rdata       (pmem_rdata)
    );

    function automatic logic [31:0] backing(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        else return a ^ 32'h5A5A_0000;
    endfunction

    // One clock: after the edge, the backing memory reacts to the new request state.
    task automatic step();
        logic [31:0] w;
        @(posedge clk);
        #1;
        if (!pmem_manual) begin
            if (pmem_read && pmem_write) both_seen = 1'b1;
            if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt == 1 && pmem_read)  rd_txn++;
                if (cnt == 1 && pmem_write) wr_txn++;
                if (cnt == lat) begin
                    pmem_resp = 1'b1;
                    if (pmem_read) pmem_rdata = backing(pmem_address);
                    if (pmem_write) begin
                        last_wr_addr = pmem_address;
                        last_wr_data = pmem_wdata;
                        last_wr_be   = pmem_byte_enable;
                        w = backing(pmem_address);
                        for (int i = 0; i < 4; i++)
                            if (pmem_byte_enable[i]) w[8*i +: 8] = pmem_wdata[8*i +: 8];
                        bmem[pmem_address] = w;
                    end
                end else begin
                    pmem_resp = 1'b0;
                end
            end else begin
                cnt = 0;
                pmem_resp = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp_data,
                            input int exp_wait, input string name);
        int w;
        mem_read = 1'b1; mem_write = 1'b0; mem_address = a;
        #1;
        w = 0;
        while (!mem_resp && w < 40) begin step(); w++; end
        checks++;
        if (w !== exp_wait) begin
            errors++;
            $display("FAIL %s_resp_wait: got %0d cycles, expected %0d", name, w, exp_wait);
        end
        step();
        mem_read = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== exp_data) begin
            errors++;
            $display("FAIL %s_data: ready=%0b rdata=%h, expected ready=1 rdata=%h",
                     name, mem_ready, mem_rdata, exp_data);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                             input logic rd_too, input int exp_wait, input string name);
        int w;
        mem_read = rd_too; mem_write = 1'b1; mem_address = a;
        mem_byte_enable = be; mem_wdata = d;
        #1;
        w = 0;
        while (!mem_resp && w < 40) begin step(); w++; end
        checks++;
        if (w !== exp_wait) begin
            errors++;
            $display("FAIL %s_resp_wait: got %0d cycles, expected %0d", name, w, exp_wait);
        end
        step();
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_ready: ready=%0b, expected 0", name, mem_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b rdata=%h pr=%0b pw=%0b, expected all 0",
                     mem_ready, mem_rdata, pmem_read, pmem_write);
        end
        checks++;
        if (mem_resp !== 1'b1) begin
            errors++;
            $display("FAIL reset_resp: got %0b, expected 1", mem_resp);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_cold_read();
        int r0 = rd_txn;
        cpu_read(32'h100, 32'hDEADBEEF, 4, "cold_read");
        checks++;
        if (rd_txn - r0 !== 1) begin
            errors++;
            $display("FAIL cold_read_txn: got %0d pmem reads, expected 1", rd_txn - r0);
        end
    endtask

    task automatic test_hit();
        int r0 = rd_txn;
        cpu_read(32'h100, 32'hDEADBEEF, 0, "hit");
        checks++;
        if (rd_txn !== r0) begin
            errors++;
            $display("FAIL hit_no_pmem: got %0d pmem reads, expected 0", rd_txn - r0);
        end
        step();
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL hit_ready_drop: got %0b, expected 0", mem_ready);
        end
    endtask

    task automatic test_write_hit();
        int w0 = wr_txn;
        cpu_write(32'h100, 4'b0010, 32'h0000AA00, 1'b0, 4, "write_hit");
        checks++;
        if (wr_txn - w0 !== 1 || last_wr_be !== 4'b0010 || last_wr_addr !== 32'h100
            || last_wr_data !== 32'h0000AA00) begin
            errors++;
            $display("FAIL write_hit_pmem: n=%0d be=%h addr=%h data=%h, expected 1 2 00000100 0000aa00",
                     wr_txn - w0, last_wr_be, last_wr_addr, last_wr_data);
        end
        cpu_read(32'h100, 32'hDEADAAEF, 0, "read_after_write");
    endtask

    task automatic test_stall();
        cpu_read(32'h104, 32'h5A5A0104, 4, "fill_104");
        cpu_read(32'h100, 32'hDEADAAEF, 0, "prior_read");
        mem_stall = 1'b1; mem_read = 1'b1; mem_address = 32'h104;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL stall_resp%0d: got %0b, expected 0", i, mem_resp);
            end
            step();
            checks++;
            if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEADAAEF) begin
                errors++;
                $display("FAIL stall_hold%0d: ready=%0b rdata=%h, expected 1 deadaaef",
                         i, mem_ready, mem_rdata);
            end
        end
        mem_stall = 1'b0;
        #1;
        checks++;
        if (mem_resp !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_resp: got %0b, expected 1", mem_resp);
        end
        step();
        mem_read = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h5A5A0104) begin
            errors++;
            $display("FAIL stall_release_data: ready=%0b rdata=%h, expected 1 5a5a0104",
                     mem_ready, mem_rdata);
        end
    endtask

    task automatic test_write_miss();
        int r0;
        cpu_write(32'h200, 4'hF, 32'h12345678, 1'b0, 4, "write_miss");
        r0 = rd_txn;
        cpu_read(32'h200, 32'h12345678, 4, "read_after_miss");
        checks++;
        if (rd_txn - r0 !== 1) begin
            errors++;
            $display("FAIL no_allocate: got %0d pmem reads, expected 1", rd_txn - r0);
        end
    endtask

    task automatic test_be_zero();
        int w0 = wr_txn;
        cpu_write(32'h200, 4'h0, 32'hFFFFFFFF, 1'b0, 4, "be_zero");
        checks++;
        if (wr_txn - w0 !== 1 || last_wr_be !== 4'h0) begin
            errors++;
            $display("FAIL be_zero_pmem: n=%0d be=%h, expected 1 0", wr_txn - w0, last_wr_be);
        end
        cpu_read(32'h200, 32'h12345678, 0, "be_zero_line");
    endtask

    task automatic test_read_and_write();
        int r0 = rd_txn;
        int w0 = wr_txn;
        cpu_write(32'h200, 4'hF, 32'hCAFEF00D, 1'b1, 4, "rw_both");
        checks++;
        if (wr_txn - w0 !== 1 || rd_txn !== r0) begin
            errors++;
            $display("FAIL rw_both_txn: writes=%0d reads=%0d, expected 1 0", wr_txn - w0, rd_txn - r0);
        end
        cpu_read(32'h200, 32'hCAFEF00D, 0, "rw_both_line");
    endtask

    task automatic test_latency1();
        lat = 1;
        cpu_read(32'h108, 32'h5A5A0108, 2, "lat1_read");
        lat = 3;
    endtask

    task automatic test_reset_fetch();
        int r0;
        lat = 5;
        mem_read = 1'b1; mem_address = 32'h10C;
        #1;
        step();
        step();
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_fetch_active: pmem_read=%0b, expected 1", pmem_read);
        end
        rst = 1'b1; mem_read = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_fetch_drop: pmem_read=%0b, expected 0", pmem_read);
        end
        pmem_manual = 1'b1;
        pmem_resp = 1'b1; pmem_rdata = 32'hBADBAD00;
        step();
        pmem_resp = 1'b0;
        pmem_manual = 1'b0;
        cnt = 0;
        lat = 3;
        r0 = rd_txn;
        cpu_read(32'h104, 32'h5A5A0104, 4, "after_rst_104");
        cpu_read(32'h10C, 32'h5A5A010C, 4, "late_resp_ignored");
        checks++;
        if (rd_txn - r0 !== 2) begin
            errors++;
            $display("FAIL after_rst_misses: got %0d pmem reads, expected 2", rd_txn - r0);
        end
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'h0;
        mem_byte_enable = 4'h0; mem_wdata = 32'h0; mem_stall = 1'b0;
        pmem_resp = 1'b0; pmem_rdata = 32'h0;
        bmem[32'h100] = 32'hDEADBEEF;

        test_reset();
        test_cold_read();
        test_hit();
        test_write_hit();
        test_stall();
        test_write_miss();
        test_be_zero();
        test_read_and_write();
        test_latency1();
        test_reset_fetch();

        checks++;
        if (both_seen !== 1'b0) begin
            errors++;
            $display("FAIL pmem_exclusive: read and write seen together=%0b, expected 0", both_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
